bouncing_square_gen: RTL
========================

// Module: bouncing_square_gen
// PURPOSE
//   Pixel-generation stage directly downstream of vga_controller in the bouncing-square design.
//   Consumes x, y, video_on, hsync and vsync, and holds the square's position and direction.
//   Moves the square by SQ_VEL pixels once per frame and bounces it off the screen edges.
//   Outputs 12-bit RGB plus re-timed syncs, so colour and sync reach the VGA pins on the same cycle.
// PARAMETERS
//   H_DISP    640      visible width in pixels
//   V_DISP    480      visible height in lines
//   SQ_SIZE   64       square side in pixels; requires SQ_SIZE+SQ_VEL <= min(H_DISP,V_DISP)
//   SQ_VEL    1        pixels moved per frame on each axis, 1..15
//   X_INIT    0        reset x of the square's top-left corner; must be <= H_DISP-SQ_SIZE
//   Y_INIT    0        reset y of the square's top-left corner; must be <= V_DISP-SQ_SIZE
//   COLOR_SQ  12'hF00  square colour, {R[3:0],G[3:0],B[3:0]}
//   COLOR_BG  12'h000  background colour inside the visible area
// PORTS
//   clk_100MHz  in   1   system clock; x/y advance one pixel per cycle
//   reset       in   1   synchronous, active-high
//   video_on    in   1   from vga_controller; high in the visible area
//   hsync_in    in   1   from vga_controller
//   vsync_in    in   1   from vga_controller
//   x           in   10  current pixel column, 0..799
//   y           in   10  current pixel line, 0..524
//   pause       in   1   high: freeze motion; display continues
//   rgb         out  12  pixel colour to the VGA pins
//   hsync_out   out  1   hsync_in delayed 1 cycle
//   vsync_out   out  1   vsync_in delayed 1 cycle
//   frame_tick  out  1   1-cycle pulse per frame; position update occurs on the same edge
//   sq_x        out  10  current square left edge
//   sq_y        out  10  current square top edge
// BEHAVIOUR
//   Reset (sampled at a clk edge, any time including mid-frame). Next cycle:
//     - rgb=0, hsync_out=0, vsync_out=0, frame_tick=0
//     - sq_x=X_INIT, sq_y=Y_INIT
//     - dir_x=1, dir_y=1 (1 = increasing)
//   Tick detect: tick_c = (x==0 && y==V_DISP), i.e. the first pixel of vertical blanking.
//     - frame_tick <= tick_c. It fires even when pause=1.
//   Motion: on an edge with tick_c=1 and pause=0, each axis updates independently.
//     - Compare in 11-bit arithmetic so nothing wraps.
//     - Rules below are for x; y is identical using V_DISP and dir_y.
//     - dir_x=1: if sq_x+SQ_VEL >= H_DISP-SQ_SIZE, then sq_x <= H_DISP-SQ_SIZE and dir_x <= 0.
//       Otherwise sq_x <= sq_x+SQ_VEL.
//     - dir_x=0: if sq_x <= SQ_VEL, then sq_x <= 0 and dir_x <= 1.
//       Otherwise sq_x <= sq_x-SQ_VEL.
//     - The square therefore never leaves [0, H_DISP-SQ_SIZE] x [0, V_DISP-SQ_SIZE].
//     - Position changes only inside blanking, so no tearing.
//   Pixel path: 1-cycle registered latency.
//     - in_sq = x>=sq_x && x<sq_x+SQ_SIZE && y>=sq_y && y<sq_y+SQ_SIZE (11-bit compares).
//     - rgb <= !video_on ? 12'h000 : (in_sq ? COLOR_SQ : COLOR_BG).
//     - hsync_out <= hsync_in; vsync_out <= vsync_in. Syncs stay aligned with rgb.
//   Simultaneous events:
//     - reset overrides tick and pause.
//     - A corner hit flips both directions on the same tick.
//   No handshake: the block is a free-running pipeline that follows its x/y inputs.
// TESTING (defaults unless stated)
//   1 reset: hold reset 2 cycles, x=0, y=0, video_on=1.
//     -> rgb=0, syncs=0, sq_x=0, sq_y=0, frame_tick=0.
//   2 pixel map, square at (0,0):
//     -> (63,63,von=1) gives rgb=F00 next cycle.
//     -> (64,63) gives 000.
//     -> (10,10,von=0) gives 000.
//     -> hsync_in pulse appears on hsync_out 1 cycle later.
//   3 motion: drive one full frame from reset.
//     -> frame_tick pulses 1 cycle after (x,y)=(0,480).
//     -> sq_x=1 and sq_y=1 on that cycle.
//     -> no other update during the frame.
//   4 right bounce, X_INIT=575, SQ_VEL=2:
//     -> tick 1: sq_x=576, dir_x=0.
//     -> tick 2: sq_x=574.
//   5 left/top corner: sq_x=1, sq_y=1, both dirs decreasing, SQ_VEL=2.
//     -> tick 1: (0,0), both dirs=1.
//     -> tick 2: (2,2).
//   6 pause=1 across 3 ticks: sq_x/sq_y unchanged, frame_tick pulses 3 times.
//     Then assert reset mid-frame -> X_INIT/Y_INIT next cycle.

Source files
------------

// File: rtl/bouncing_square_gen.sv
// Pixel stage behind vga_controller: draws a square that moves once per frame and bounces off the screen edges.
// Colour and syncs are registered together so they reach the pins on the same cycle.
module bouncing_square_gen #(
   parameter int unsigned H_DISP   = 640,
   parameter int unsigned V_DISP   = 480,
   parameter int unsigned SQ_SIZE  = 64,
   parameter int unsigned SQ_VEL   = 1,
   parameter int unsigned X_INIT   = 0,
   parameter int unsigned Y_INIT   = 0,
   parameter logic [11:0] COLOR_SQ = 12'hF00,
   parameter logic [11:0] COLOR_BG = 12'h000
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        pause,
   output logic [11:0] rgb,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        frame_tick,
   output logic [9:0]  sq_x,
   output logic [9:0]  sq_y
);

   localparam int unsigned PW = 10;
   localparam int unsigned CW = 11;

   localparam logic [CW-1:0] X_MAX = CW'(H_DISP - SQ_SIZE);
   localparam logic [CW-1:0] Y_MAX = CW'(V_DISP - SQ_SIZE);
   localparam logic [CW-1:0] VEL   = CW'(SQ_VEL);
   localparam logic [CW-1:0] SIZE  = CW'(SQ_SIZE);

   logic          dir_x;
   logic          dir_y;
   logic          tick_c;
   logic          in_sq_c;
   logic [PW-1:0] nx_x_c;
   logic [PW-1:0] nx_y_c;
   logic          nx_dir_x_c;
   logic          nx_dir_y_c;

   // One axis of motion: returns {new_dir, new_pos}, clamping to [0, lim]
   function automatic logic [PW:0] step_axis(input logic [PW-1:0] pos,
                                             input logic          dir,
                                             input logic [CW-1:0] lim);
      logic [CW-1:0] p;
      logic [PW:0]   r;
      p = CW'(pos);
      if (dir) begin
         if (p + VEL >= lim) r = {1'b0, PW'(lim)};
         else                r = {1'b1, PW'(p + VEL)};
      end else begin
         if (p <= VEL)       r = {1'b1, PW'(0)};
         else                r = {1'b0, PW'(p - VEL)};
      end
      return r;
   endfunction

   always_comb begin
      tick_c  = 1'b0;
      in_sq_c = 1'b0;
      {nx_dir_x_c, nx_x_c} = step_axis(sq_x, dir_x, X_MAX);
      {nx_dir_y_c, nx_y_c} = step_axis(sq_y, dir_y, Y_MAX);
      tick_c  = (x == PW'(0)) && (CW'(y) == CW'(V_DISP));
      in_sq_c = (CW'(x) >= CW'(sq_x)) && (CW'(x) < CW'(sq_x) + SIZE) &&
                (CW'(y) >= CW'(sq_y)) && (CW'(y) < CW'(sq_y) + SIZE);
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         rgb        <= 12'h000;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         frame_tick <= 1'b0;
         sq_x       <= PW'(X_INIT);
         sq_y       <= PW'(Y_INIT);
         dir_x      <= 1'b1;
         dir_y      <= 1'b1;
      end else begin
         rgb        <= !video_on ? 12'h000 : (in_sq_c ? COLOR_SQ : COLOR_BG);
         hsync_out  <= hsync_in;
         vsync_out  <= vsync_in;
         frame_tick <= tick_c;
         // Motion lands on the first blanking line, so the visible frame never tears
         if (tick_c && !pause) begin
            sq_x  <= nx_x_c;
            sq_y  <= nx_y_c;
            dir_x <= nx_dir_x_c;
            dir_y <= nx_dir_y_c;
         end
      end
   end

endmodule
